// File: rtl/spram_pkg.sv
// rtl/spram_pkg.sv - shared constants and helpers for the SRAM controller and its SRAM instance
package spram_pkg;

    function automatic int spram_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    typedef logic [1:0] spram_state_t;

    localparam spram_state_t ST_BOOT = 2'd0;
    localparam spram_state_t ST_INIT = 2'd1;
    localparam spram_state_t ST_RUN  = 2'd2;

    localparam int SPRAM_DEPTH_DEFAULT = 4096;
    localparam int SPRAM_AW_DEFAULT    = spram_clog2(SPRAM_DEPTH_DEFAULT);

endpackage

// File: rtl/spram_ctrl_rsp_fifo.sv
// rtl/spram_ctrl_rsp_fifo.sv - small synchronous FIFO holding read responses until consumed
module spram_ctrl_rsp_fifo
    import spram_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    localparam int PW = spram_clog2(DEPTH),
    localparam int CW = spram_clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [WIDTH-1:0] slot_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign head    = slot_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            slot_d[wr_ptr_q] = push_data;
            wr_ptr_d         = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/spram_ctrl.sv
// rtl/spram_ctrl.sv - request/response front end for a single-port SRAM with post-reset clear sweep
module spram_ctrl
    import spram_pkg::*;
#(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = SPRAM_DEPTH_DEFAULT,
    parameter int RSP_DEPTH = 3,
    parameter int INIT_EN   = 1,
    parameter logic [MEM_WIDTH-1:0] INIT_VALUE = MEM_WIDTH'(1),
    localparam int AW = spram_clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [AW-1:0]        req_addr,
    input  logic [MEM_WIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [MEM_WIDTH-1:0] rsp_rdata,
    output logic                 init_done,
    output logic                 mem_cen,
    output logic                 mem_wen,
    output logic [AW-1:0]        mem_addr,
    output logic [MEM_WIDTH-1:0] mem_d,
    input  logic [MEM_WIDTH-1:0] mem_q
);

    localparam int CW = spram_clog2(RSP_DEPTH + 1);

    spram_state_t  state_q, state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;
    logic          rd_pend_q, rd_pend_d;
    logic          fire;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          fifo_empty;
    logic          fifo_full;

    // A read in flight still owns a FIFO slot, so it counts against credit.
    assign credit_used = {1'b0, fifo_count} + (CW + 1)'(rd_pend_q);
    assign req_ready   = (state_q == ST_RUN) && (credit_used < (CW + 1)'(RSP_DEPTH));
    assign fire        = req_valid & req_ready;
    assign init_done   = (state_q == ST_RUN);
    assign rsp_valid   = ~fifo_empty;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        rd_pend_d  = fire & ~req_we;
        case (state_q)
            ST_BOOT: state_d = (INIT_EN != 0) ? ST_INIT : ST_RUN;
            ST_INIT: begin
                init_cnt_d = init_cnt_q + AW'(1);
                if (init_cnt_q == AW'(MEM_DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        mem_cen  = 1'b1;
        mem_wen  = 1'b1;
        mem_addr = '0;
        mem_d    = '0;
        case (state_q)
            ST_INIT: begin
                mem_cen  = 1'b0;
                mem_wen  = 1'b0;
                mem_addr = init_cnt_q;
                mem_d    = INIT_VALUE;
            end
            ST_RUN: begin
                mem_cen  = ~fire;
                mem_wen  = ~req_we;
                mem_addr = req_addr;
                mem_d    = req_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            init_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    spram_ctrl_rsp_fifo #(
        .WIDTH (MEM_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend_q),
        .push_data (mem_q),
        .pop       (rsp_valid & rsp_ready),
        .head      (rsp_rdata),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: doc/spram_ctrl.md
# spram_ctrl

Initiator-side controller for the single-port behavioural/hard SRAM (cen/wen/addr/d/q, active-low enables, 1-cycle registered read). It converts a valid/ready request stream into SRAM cycles. It returns read data on a valid/ready response stream through a small response FIFO, so downstream backpressure never loses data. After reset it performs an optional clear sweep that writes INIT_VALUE to every address, because real SRAM macros power up undefined.

## Interface
Parameters:
- MEM_WIDTH, 32, data width; must match the SRAM instance
- MEM_DEPTH, 4096, number of words; AW = clog2(MEM_DEPTH)
- RSP_DEPTH, 3, response FIFO entries; minimum 2
- INIT_EN, 1, 1 = run clear sweep after reset; 0 = skip it
- INIT_VALUE, 1, word written by the sweep

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when both valid and ready are high
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  word address
- req_wdata  in  MEM_WIDTH  write data
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  MEM_WIDTH  read data, in request order
- init_done  out  1  high once the block is in RUN
- mem_cen  out  1  SRAM chip enable, active low
- mem_wen  out  1  SRAM write enable, active low
- mem_addr  out  AW  SRAM address
- mem_d  out  MEM_WIDTH  SRAM write data
- mem_q  in  MEM_WIDTH  SRAM read data

## Operation
- State machine: BOOT, then INIT, then RUN.
  - Reset value is BOOT.
  - BOOT → INIT on the first clock after reset release when INIT_EN = 1; BOOT → RUN when INIT_EN = 0.
  - INIT → RUN after the write to address MEM_DEPTH-1.
  - RUN is terminal until the next reset.
- SRAM outputs are combinational from state and handshake:
  - BOOT: mem_cen = 1, mem_wen = 1, mem_addr = 0, mem_d = 0.
  - INIT: mem_cen = 0, mem_wen = 0, mem_addr = init_cnt, mem_d = INIT_VALUE. init_cnt resets to 0 and increments every cycle.
  - RUN: fire = req_valid & req_ready. mem_cen = ~fire, mem_wen = ~req_we, mem_addr = req_addr, mem_d = req_wdata. When fire is 0, mem_cen = 1 and mem_addr/mem_d hold the request inputs (don't-care).
- Read tracking:
  - A read fire sets rd_pend for the next cycle.
  - While rd_pend = 1, mem_q is pushed into the response FIFO at the end of that cycle.
  - Writes produce no response.
- Credit rule: req_ready = (state == RUN) & (fifo_count + rd_pend < RSP_DEPTH). This has no combinational dependence on req_valid, req_we or rsp_ready.
- Response FIFO:
  - rsp_valid = fifo non-empty; rsp_rdata = head entry.
  - Pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Overflow is impossible by the credit rule. The bench must still assert that a push never occurs when the FIFO is full.
- Ordering: responses come out strictly in read-issue order. A write issued after a read to the same address does not affect that read's data. A read issued after a write returns the new data.
- Reset mid-operation: all state clears at once.
  - FIFO is emptied, rd_pend = 0, init_cnt = 0, state = BOOT.
  - In-flight reads are discarded.
  - The sweep restarts from address 0 after release.

## Timing
- Reset values: req_ready 0, rsp_valid 0, init_done 0, mem_cen 1, mem_wen 1, mem_addr 0, mem_d 0, rsp_rdata 0.
- Sweep: starts one cycle after reset release and lasts exactly MEM_DEPTH cycles. init_done and req_ready (when there is credit) rise in the cycle after the last sweep write.
- Read latency: a read accepted in cycle N has its data in the FIFO at the end of cycle N+1. rsp_valid is high in cycle N+2 at the earliest.
- Throughput: with RSP_DEPTH ≥ 3 and rsp_ready held at 1, one read or write is accepted every cycle. With RSP_DEPTH = 2, reads are limited to 2 per 3 cycles.
- Writes complete at the accept edge; there is no write latency.

## Structure
- Package spram_pkg holds:
  - the clog2 function;
  - the state enum (BOOT/INIT/RUN, 2 bits);
  - the localparam for AW derivation, so the SRAM and the controller share it.
- One sub-module, spram_ctrl_rsp_fifo:
  - synchronous FIFO of RSP_DEPTH × MEM_WIDTH with asynchronous active-low reset;
  - ports: push, push_data, pop, head, count, empty, full.
- Top level holds the FSM, init_cnt, rd_pend, the credit logic and the SRAM muxing.

## Test plan
- Sweep, MEM_DEPTH = 16, INIT_EN = 1: release reset → mem_cen = 0 and mem_wen = 0 for exactly 16 cycles at addr 0..15 with d = 1; init_done rises in the next cycle. Then read addr 7 → rsp_rdata = 1.
- Write/read back: write 0xDEADBEEF to addr 3, then read addr 3 in the next cycle → one response 0xDEADBEEF, rsp_valid first high 2 cycles after the read accept.
- Streaming: 8 back-to-back reads of addr 0..7 (preloaded with data = addr), rsp_ready = 1 → req_ready stays 1, responses 0..7 in order on 8 consecutive cycles.
- Backpressure: rsp_ready = 0, offer 5 reads → exactly 3 accepted, then req_ready = 0. Raise rsp_ready → 3 correct in-order responses, no loss or duplication, and the remaining reads then proceed.
- Reset mid-sweep and mid-read: assert rst_n = 0 at sweep address 5, and separately with 2 reads in flight → outputs immediately at reset values, FIFO empty, the sweep restarts at address 0, and no stale response appears afterwards.
- INIT_EN = 0: init_done and req_ready are high 1 cycle after reset release, and the first cycle with mem_cen = 0 is a request fire.
